// File: rtl/chacha_pkg.sv
// ChaCha shared definitions: word type, quarter-round index tables, rotate amounts, FSM encoding.
// Latency: none; types, constants and combinational helpers only.
// Backpressure: not applicable.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  widx_t;

    // Word indices (a, b, c, d) of the four column quarter-rounds, in issue order
    localparam widx_t COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    // Word indices (a, b, c, d) of the four diagonal quarter-rounds, in issue order
    localparam widx_t DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    localparam int ROT_1 = 16;
    localparam int ROT_2 = 12;
    localparam int ROT_3 = 8;
    localparam int ROT_4 = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FF   = 2'd2
    } state_t;

    function automatic word_t rotl(input word_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // State word feeding operand 'pos' of quarter-round 'qr' in a column or diagonal half-round
    function automatic widx_t qr_word(input logic diag, input logic [1:0] qr, input logic [1:0] pos);
        return diag ? DIAG_IDX[qr][pos] : COL_IDX[qr][pos];
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// ChaCha quarter-round on four 32-bit words.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    word_t a1, b1, c1, d1;
    word_t a2, b2, c2, d2;

    assign a1 = a_i + b_i;
    assign d1 = rotl(d_i ^ a1, ROT_1);
    assign c1 = c_i + d1;
    assign b1 = rotl(b_i ^ c1, ROT_2);
    assign a2 = a1 + b1;
    assign d2 = rotl(d1 ^ a2, ROT_3);
    assign c2 = c1 + d2;
    assign b2 = rotl(b1 ^ c2, ROT_4);

    assign a_o = a2;
    assign b_o = b2;
    assign c_o = c2;
    assign d_o = d2;

endmodule

// File: rtl/chacha_block_core.sv
// ChaCha block engine: byte-addressed 16-word state, LANES quarter-rounds per cycle, optional feed-forward.
// Latency: 4*ROUNDS/LANES run cycles plus one feed-forward cycle; done pulses after the last update.
// Backpressure: none; wr_en and start are ignored while busy, start loses to a same-cycle write.
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS      = 20,
    parameter int LANES       = 1,
    parameter int FEEDFORWARD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] addr,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       start,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done
);

    localparam int K   = 4 * ROUNDS / LANES;
    localparam int SW  = $clog2(K);
    localparam int LSH = $clog2(LANES);

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic          done_q, done_d;
    word_t         st_q [16];
    word_t         st_d [16];
    word_t         sv_q [16];

    logic       start_acc;
    logic       last_step;
    logic       diag;
    logic [1:0] qbase;

    assign start_acc = (state_q == ST_IDLE) && start && !wr_en;
    assign last_step = (step_q == SW'(K - 1));

    // Steps per half-round is 4/LANES, so the half-round parity sits at step bit 2-LSH
    assign diag = step_q[2 - LSH];

    if (LANES == 4) begin : g_qb4
        assign qbase = 2'd0;
    end else if (LANES == 2) begin : g_qb2
        assign qbase = {step_q[0], 1'b0};
    end else begin : g_qb1
        assign qbase = step_q[1:0];
    end

    widx_t ln_idx [LANES][4];
    word_t ln_in  [LANES][4];
    word_t ln_out [LANES][4];

    // Lanes within one step hit disjoint words of the same half-round, so they update in place together
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] qsel;
        assign qsel = qbase + 2'(l);

        for (genvar p = 0; p < 4; p++) begin : g_pos
            assign ln_idx[l][p] = qr_word(diag, qsel, 2'(p));
            assign ln_in[l][p]  = st_q[ln_idx[l][p]];
        end

        chacha_qr u_qr (
            .a_i (ln_in[l][0]),
            .b_i (ln_in[l][1]),
            .c_i (ln_in[l][2]),
            .d_i (ln_in[l][3]),
            .a_o (ln_out[l][0]),
            .b_o (ln_out[l][1]),
            .c_o (ln_out[l][2]),
            .d_o (ln_out[l][3])
        );
    end

    // Next-state: sequencing IDLE -> RUN -> (FF) -> IDLE with step counter and done pulse
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    step_d  = '0;
                    done_d  = (FEEDFORWARD == 0);
                    state_d = (FEEDFORWARD != 0) ? ST_FF : ST_IDLE;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            ST_FF: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working state next value: host byte write, quarter-round lanes, or feed-forward add
    always_comb begin
        st_d = st_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    st_d[addr[5:2]][{addr[1:0], 3'b000} +: 8] = wr_data;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    for (int p = 0; p < 4; p++) begin
                        st_d[ln_idx[l][p]] = ln_out[l][p];
                    end
                end
            end
            ST_FF: begin
                for (int i = 0; i < 16; i++) begin
                    st_d[i] = st_q[i] + sv_q[i];
                end
            end
            default: ;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    // Working state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) st_q[i] <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    // Snapshot of the input block taken at start, added back in the FF cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) sv_q[i] <= '0;
        end else if (start_acc && (FEEDFORWARD != 0)) begin
            for (int i = 0; i < 16; i++) sv_q[i] <= st_q[i];
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign rd_data = st_q[addr[5:2]][{addr[1:0], 3'b000} +: 8];

endmodule

// File: tb/tb_chacha_block_core.sv
// Bench for chacha_block_core: four configurations share one host bus, results scored against a ChaCha model.
// Latency: done latency per configuration is measured in cycles from the start edge.
// Backpressure: writes and starts issued while busy must leave the computed result unchanged.
module tb_chacha_block_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       start;
    logic [7:0] rd_a, rd_b, rd_c, rd_q;
    logic       busy_a, busy_b, busy_c, busy_q;
    logic       done_a, done_b, done_c, done_q;

    always #5 clk = ~clk;

    chacha_block_core u_dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
        .start(start), .rd_data(rd_a), .busy(busy_a), .done(done_a)
    );
    chacha_block_core #(.LANES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
        .start(start), .rd_data(rd_b), .busy(busy_b), .done(done_b)
    );
    chacha_block_core #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
        .start(start), .rd_data(rd_c), .busy(busy_c), .done(done_c)
    );
    chacha_block_core #(.LANES(1), .FEEDFORWARD(0)) u_qr (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
        .start(start), .rd_data(rd_q), .busy(busy_q), .done(done_q)
    );

    localparam int LAT [4] = '{82, 42, 22, 81};
    localparam logic [31:0] RFC [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000
    };
    localparam logic [31:0] QIN  [4] = '{32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
    localparam logic [31:0] QOUT [4] = '{32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
    localparam int QI [8][4] = '{
        '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
    };

    int          n_vec = 0;
    int          n_err = 0;
    int          n_done [4] = '{0, 0, 0, 0};
    logic [31:0] sb_q [$];
    logic [31:0] cur [4][16];
    logic [31:0] res [4][16];
    logic [31:0] rw  [4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_of(input int k);
        case (k)
            0: return rd_a;
            1: return rd_b;
            2: return rd_c;
            default: return rd_q;
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0: return busy_a;
            1: return busy_b;
            2: return busy_c;
            default: return busy_q;
        endcase
    endfunction

    function automatic logic done_of(input int k);
        case (k)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            default: return done_q;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (done_of(k) === 1'b1) n_done[k]++;
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] mqr(input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Reference block function: advances the expected state of configuration k
    task automatic model_run(input int k);
        logic [31:0]  x [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) x[i] = cur[k][i];
        for (int dr = 0; dr < 10; dr++) begin
            for (int j = 0; j < 8; j++) begin
                r = mqr(x[QI[j][0]], x[QI[j][1]], x[QI[j][2]], x[QI[j][3]]);
                x[QI[j][0]] = r[127:96];
                x[QI[j][1]] = r[95:64];
                x[QI[j][2]] = r[63:32];
                x[QI[j][3]] = r[31:0];
            end
        end
        if (k != 3) for (int i = 0; i < 16; i++) x[i] = x[i] + cur[k][i];
        for (int i = 0; i < 16; i++) cur[k][i] = x[i];
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) for (int i = 0; i < 16; i++) cur[k][i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_model();
    endtask

    task automatic wr_byte(input logic [5:0] a, input logic [7:0] d, input bit track);
        @(negedge clk);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge clk); #1 wr_en = 1'b0;
        if (track) for (int k = 0; k < 4; k++) cur[k][a[5:2]][{a[1:0], 3'b000} +: 8] = d;
    endtask

    task automatic wr_word(input int w, input logic [31:0] v);
        for (int b = 0; b < 4; b++) wr_byte(6'(w * 4 + b), v[8 * b +: 8], 1'b1);
    endtask

    task automatic load_rfc();
        for (int w = 0; w < 16; w++) wr_word(w, RFC[w]);
    endtask

    task automatic read_word(input int w);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            addr = 6'(w * 4 + b);
            #1;
            for (int k = 0; k < 4; k++) rw[k][8 * b +: 8] = rd_of(k);
        end
    endtask

    // Start all configurations, time their done pulses, optionally read back and score the results
    task automatic run_and_check(input string tag, input bit interfere, input bit chain, input bit readout);
        int lat  [4];
        int snap [4];
        int m;
        for (int k = 0; k < 4; k++) model_run(k);
        if (readout) for (int w = 0; w < 16; w++) for (int k = 0; k < 4; k++) sb_q.push_back(cur[k][w]);
        if (!chain) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) snap[k] = n_done[k];
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 4; k++) lat[k] = 0;
        m = 0;
        while (m < 300 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0 || lat[3] == 0)) begin
            @(negedge clk);
            m++;
            if (interfere && m == 5) begin
                addr = 6'd0; wr_data = 8'hff; wr_en = 1'b1; start = 1'b1;
            end
            if (interfere && m == 6) wr_en = 1'b0;
            if (interfere && m == 11) start = 1'b0;
            for (int k = 0; k < 4; k++) if (lat[k] == 0 && done_of(k)) lat[k] = m;
        end
        for (int k = 0; k < 4; k++) check_val($sformatf("%s latency cfg%0d", tag, k), lat[k], LAT[k]);
        if (readout) begin
            for (int w = 0; w < 16; w++) begin
                read_word(w);
                for (int k = 0; k < 4; k++) begin
                    res[k][w] = rw[k];
                    check_val($sformatf("%s cfg%0d word%0d", tag, k, w), rw[k], sb_q.pop_front());
                end
            end
            if (!chain) for (int k = 0; k < 4; k++)
                check_val($sformatf("%s done pulses cfg%0d", tag, k), n_done[k] - snap[k], 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          snap [4];
        logic [31:0] got;

        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; addr = '0; wr_data = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset values after arbitrary writes
        wr_byte(6'd0, 8'h5a, 1'b1);
        wr_byte(6'd21, 8'hc3, 1'b1);
        wr_byte(6'd63, 8'h7e, 1'b1);
        @(negedge clk); addr = 6'd21; #1;
        check_val("write visible", rd_a, 8'hc3);
        #1 rst_n = 1'b0;
        #1;
        check_val("reset rd immediate", rd_a, 8'h00);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("reset busy cfg%0d", k), busy_of(k), 1'b0);
            check_val($sformatf("reset done cfg%0d", k), done_of(k), 1'b0);
        end
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a); #1;
            for (int k = 0; k < 4; k++) check_val($sformatf("reset byte%0d cfg%0d", a, k), rd_of(k), 8'h00);
        end
        @(negedge clk); rst_n = 1'b1;
        clear_model();

        // Byte load and readback
        for (int a = 0; a < 64; a++) wr_byte(6'(a), 8'(a), 1'b1);
        for (int w = 0; w < 16; w++) begin
            read_word(w);
            for (int k = 0; k < 4; k++)
                check_val($sformatf("load word%0d cfg%0d", w, k), rw[k],
                          {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
            if (w == 3) check_val("load word3 literal", rw[0], 32'h0f0e0d0c);
        end

        // Single quarter-round after the first update edge, one word per run
        for (int wi = 0; wi < 4; wi++) begin
            do_reset();
            for (int j = 0; j < 4; j++) wr_word(4 * j, QIN[j]);
            sb_q.push_back(QOUT[wi]);
            @(negedge clk); start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            got = '0;
            for (int m = 1; m <= 5; m++) begin
                @(negedge clk);
                if (m == 2) check_val($sformatf("qr busy run%0d", wi), busy_q, 1'b1);
                if (m >= 2) begin
                    addr = 6'(16 * wi + m - 2);
                    #1 got[8 * (m - 2) +: 8] = rd_q;
                end
            end
            check_val($sformatf("qr word%0d", 4 * wi), got, sb_q.pop_front());
        end

        // RFC 8439 block in every configuration
        do_reset();
        load_rfc();
        run_and_check("rfc", 1'b0, 1'b0, 1'b1);
        check_val("rfc word0 lanes1", res[0][0], 32'he4e7f110);
        check_val("rfc word15 lanes1", res[0][15], 32'h4e3c50a2);
        check_val("rfc word0 lanes2", res[1][0], 32'he4e7f110);
        check_val("rfc word15 lanes4", res[2][15], 32'h4e3c50a2);

        // start together with wr_en: write lands, nothing runs
        for (int k = 0; k < 4; k++) snap[k] = n_done[k];
        @(negedge clk);
        addr = 6'd0; wr_data = 8'haa; wr_en = 1'b1; start = 1'b1;
        @(posedge clk); #1 wr_en = 1'b0; start = 1'b0;
        for (int k = 0; k < 4; k++) cur[k][0][7:0] = 8'haa;
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("wr+start busy cfg%0d", k), busy_of(k), 1'b0);
            check_val($sformatf("wr+start byte cfg%0d", k), rd_of(k), 8'haa);
        end
        repeat (100) @(negedge clk);
        for (int k = 0; k < 4; k++) check_val($sformatf("wr+start no done cfg%0d", k), n_done[k] - snap[k], 0);

        // Host traffic while busy, then restart in the done cycle
        load_rfc();
        run_and_check("busy", 1'b1, 1'b0, 1'b0);
        run_and_check("b2b", 1'b0, 1'b1, 1'b1);

        // Reset pulse in the middle of a run
        do_reset();
        load_rfc();
        @(negedge clk);
        for (int k = 0; k < 4; k++) snap[k] = n_done[k];
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        clear_model();
        #1;
        for (int k = 0; k < 4; k++) check_val($sformatf("abort busy cfg%0d", k), busy_of(k), 1'b0);
        for (int w = 0; w < 16; w++) begin
            read_word(w);
            for (int k = 0; k < 4; k++) check_val($sformatf("abort word%0d cfg%0d", w, k), rw[k], 32'h0);
        end
        repeat (100) @(negedge clk);
        for (int k = 0; k < 4; k++) check_val($sformatf("abort no done cfg%0d", k), n_done[k] - snap[k], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chacha_block_core.md
# chacha_block_core

Parametrised ChaCha block-function engine, the successor of the single quarter-round block. It holds a full 16-word (512-bit) ChaCha state, loaded and read a byte at a time. On `start` it runs a configurable number of double rounds using `LANES` parallel quarter-round units, then optionally performs the RFC 8439 feed-forward addition of the initial state. It sits behind the same narrow byte-wide host interface used by the existing Tiny Tapeout top level.

## Interface

Parameters:
- `ROUNDS`, default 20: total rounds. Must be even and ≥ 2 (8/12/20 typical).
- `LANES`, default 1: quarter-rounds evaluated per cycle. Legal values are 1, 2 and 4.
- `FEEDFORWARD`, default 1: when 1, add the saved initial state to the final state before `done`.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `addr`, in, 6: byte address. `addr[5:2]` selects the word (0–15); `addr[1:0]` selects the byte (0 = bits 7:0).
- `wr_data`, in, 8: write byte.
- `wr_en`, in, 1: write the selected byte on this edge (IDLE only).
- `start`, in, 1: begin a block computation (IDLE only).
- `rd_data`, out, 8: selected byte of the working state (combinational).
- `busy`, out, 1: computation in progress.
- `done`, out, 1: one-cycle pulse when the result is valid.

## Operation

- State machine: IDLE → RUN → (FF if `FEEDFORWARD`) → IDLE.
- **IDLE**
  - `wr_en` writes one byte of the working state.
  - `start` with `wr_en` low does two things: copies the working state into the 16-word save register (only when `FEEDFORWARD`=1), and enters RUN with the step counter at 0.
  - If `wr_en` and `start` are both high, the write is performed and `start` is ignored.
- **RUN**
  - Each cycle applies `LANES` quarter-rounds of the current half-round in place. One half-round is 4 QRs.
  - Column QRs: (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - Diagonal QRs: (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - Half-rounds alternate column, diagonal, starting with column. Within a half-round, QRs issue in the order listed, lowest index first.
  - The QR is ChaCha's: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All additions are mod 2^32.
  - Total steps K = 4·`ROUNDS`/`LANES`. The step counter wraps at K.
- **FF**: one cycle; word[i] ← word[i] + save[i] mod 2^32 for all i.
- While `busy`: `wr_en` and `start` are ignored. `rd_data` shows the in-progress state.
- After `done`, the result stays readable and writable in IDLE. It can be restarted directly, e.g. after the host increments the counter word 12.

## Timing

- Reset (asynchronous, `rst_n` low): all state and save words are 0, FSM is IDLE, counter is 0, `busy`=0, `done`=0, `rd_data`=0x00.
- Reset asserted mid-RUN or mid-FF aborts immediately to the reset state. No `done` is produced.
- A byte write takes effect at the edge where `wr_en` is high. It is visible on `rd_data` the following cycle.
- Let `start` be accepted at edge E:
  - `busy` is high from E.
  - RUN updates occur at edges E+1 … E+K.
  - FF occurs at edge E+K+1 (when enabled).
  - `busy` falls, and `done` is high for exactly one cycle, after the last update edge.
- Total latency from accepting `start` to the `done` cycle:
  - K+2 cycles with `FEEDFORWARD`=1. The default is 82.
  - K+1 cycles with `FEEDFORWARD`=0.

## Structure

- Package `chacha_pkg` holds:
  - the 32-bit word type;
  - the column and diagonal QR index tables;
  - the rotate amounts (16, 12, 8, 7);
  - the FSM state encoding.
- Sub-module `chacha_qr` is a purely combinational quarter-round. It is instantiated `LANES` times.
- Each lane's operands are muxed from the state using the index tables, the half-round parity and the step counter.

## Test plan

- **Reset values:** write arbitrary bytes, assert `rst_n` low asynchronously between clock edges. Required: every address reads 0x00 at once; `busy` and `done` are 0.
- **Byte load/readback:** write 0x00–0x3F to addresses 0–63. Required: each reads back its own value; word 3 reads as 0x0F0E0D0C.
- **Single QR check** (`LANES`=1, `FEEDFORWARD`=0, all other words 0):
  - Stimulus: load words 0, 4, 8, 12 with 0x11111111, 0x01020304, 0x9b8d6f43, 0x01234567, then start.
  - Required, sampled one cycle after E+1: words are 0xea2a92f4, 0xcb1cf8ce, 0x4581472e, 0x5881c4bb.
- **RFC 8439 §2.3.2 block** (defaults):
  - Stimulus: constants; key 00..1f; counter 1; nonce 000000090000004a00000000.
  - Required: `done` pulses 82 cycles after start; word 0 = 0xe4e7f110; word 15 = 0x4e3c50a2.
  - Repeat for `LANES`=2 and `LANES`=4 with latencies 42 and 22; results must be identical.
- **Protocol edges:**
  - `start` and `wr_en` in the same cycle: the write lands, no run starts.
  - `wr_en` and `start` during `busy`: no effect on the result.
  - Back-to-back restart right after `done`: runs correctly.
- **Mid-run reset:** pulse `rst_n` at E+10. Required: FSM returns to IDLE, state is all zero, no `done` pulse.
